// File: rtl/odd_shift_rotate_unit.sv
// Odd-pipe quadword shift/rotate unit: bit/byte shifts and rotates computed in one
// combinational step, captured in stage 1, then carried down a valid/flush delay chain
// with per-stage forwarding taps.
module odd_shift_rotate_unit #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned IMM_W  = 7,
  parameter int unsigned STAGES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic                       flush,
  input  logic [2:0]                 mode,
  input  logic [DATA_W-1:0]          ra_input,
  input  logic [DATA_W-1:0]          rb_input,
  input  logic [IMM_W-1:0]           I7_input,
  input  logic [ADDR_W-1:0]          rt_address_input,
  output logic [DATA_W-1:0]          rt_value,
  output logic [ADDR_W-1:0]          rt_address,
  output logic                       wrt_en,
  output logic [STAGES-1:0]          fw_valid,
  output logic [STAGES*ADDR_W-1:0]   fw_addr,
  output logic [STAGES*DATA_W-1:0]   fw_value
);

  localparam int unsigned Bytes    = DATA_W / 8;
  localparam int unsigned RotCntW  = $clog2(Bytes);
  localparam int unsigned ByteCntW = RotCntW + 1;

  typedef enum logic [2:0] {
    OpNop     = 3'd0,
    OpShlqbi  = 3'd1,
    OpShlqbii = 3'd2,
    OpShlqby  = 3'd3,
    OpShlqbyi = 3'd4,
    OpRotqbi  = 3'd5,
    OpRotqby  = 3'd6,
    OpRotqbyi = 3'd7
  } op_e;

  op_e                  op;
  logic [15:0]          cnt_src;
  logic [2:0]           bit_cnt;
  logic [ByteCntW-1:0]  byte_cnt;
  int unsigned          byte_shift;
  int unsigned          rot_shift;
  logic [2*DATA_W-1:0]  rot_wide;
  logic [DATA_W-1:0]    result;

  logic                 valid_q [STAGES];
  logic [ADDR_W-1:0]    addr_q  [STAGES];
  logic [DATA_W-1:0]    value_q [STAGES];

  // Only the rightmost count bits are architecturally meaningful.
  logic unused_cnt;
  assign unused_cnt = ^{rb_input[DATA_W-1:16], cnt_src};

  assign op = op_e'(mode);

  // Count source select; the unused operand is never looked at, so X on it cannot leak.
  always_comb begin
    cnt_src = '0;
    unique case (op)
      OpShlqbi, OpShlqby, OpRotqbi, OpRotqby: cnt_src = rb_input[15:0];
      OpShlqbii, OpShlqbyi, OpRotqbyi:        cnt_src = 16'(I7_input);
      default:                                cnt_src = '0;
    endcase
  end

  assign bit_cnt    = cnt_src[2:0];
  assign byte_cnt   = cnt_src[ByteCntW-1:0];
  assign byte_shift = 32'(byte_cnt) * 8;
  assign rot_shift  = (32'(cnt_src[RotCntW-1:0]) % Bytes) * 8;

  // Shift/rotate datapath; rotates shift a doubled copy and keep the upper half.
  always_comb begin
    result   = '0;
    rot_wide = '0;
    unique case (op)
      OpShlqbi, OpShlqbii: result = ra_input << bit_cnt;
      OpShlqby, OpShlqbyi: begin
        if (32'(byte_cnt) >= Bytes) result = '0;
        else                        result = ra_input << byte_shift;
      end
      OpRotqbi: begin
        rot_wide = {ra_input, ra_input} << bit_cnt;
        result   = rot_wide[2*DATA_W-1 -: DATA_W];
      end
      OpRotqby, OpRotqbyi: begin
        rot_wide = {ra_input, ra_input} << rot_shift;
        result   = rot_wide[2*DATA_W-1 -: DATA_W];
      end
      default: result = '0;
    endcase
  end

  // Stage 1 captures the result; later stages are plain delays. Flush kills every valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        addr_q[s]  <= '0;
        value_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= valid_in && !flush && (op != OpNop);
      addr_q[0]  <= rt_address_input;
      value_q[0] <= result;
      for (int unsigned s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1] && !flush;
        addr_q[s]  <= addr_q[s-1];
        value_q[s] <= value_q[s-1];
      end
    end
  end

  // Forwarding taps and writeback, all gated by their stage valid.
  always_comb begin
    fw_valid = '0;
    fw_addr  = '0;
    fw_value = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      fw_valid[s]                  = valid_q[s];
      fw_addr[s*ADDR_W +: ADDR_W]  = valid_q[s] ? addr_q[s]  : '0;
      fw_value[s*DATA_W +: DATA_W] = valid_q[s] ? value_q[s] : '0;
    end
    wrt_en     = valid_q[STAGES-1];
    rt_address = valid_q[STAGES-1] ? addr_q[STAGES-1]  : '0;
    rt_value   = valid_q[STAGES-1] ? value_q[STAGES-1] : '0;
  end

endmodule

// File: tb/tb_odd_shift_rotate_unit.sv
// Scoreboard bench for odd_shift_rotate_unit: a 128-bit/4-stage and a 64-bit/1-stage
// instance share one stimulus stream; each has its own expected-result queue.
module tb_odd_shift_rotate_unit;

  logic         clock = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         flush;
  logic [2:0]   mode;
  logic [127:0] ra;
  logic [127:0] rb;
  logic [6:0]   i7;
  logic [6:0]   addr_in;

  logic [127:0] rt_value_a;
  logic [6:0]   rt_address_a;
  logic         wrt_en_a;
  logic [3:0]   fw_valid_a;
  logic [27:0]  fw_addr_a;
  logic [511:0] fw_value_a;

  logic [63:0]  rt_value_b;
  logic [6:0]   rt_address_b;
  logic         wrt_en_b;
  logic [0:0]   fw_valid_b;
  logic [6:0]   fw_addr_b;
  logic [63:0]  fw_value_b;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int unsigned  due;
    logic [127:0] val;
    logic [6:0]   addr;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  odd_shift_rotate_unit #(.DATA_W(128), .ADDR_W(7), .IMM_W(7), .STAGES(4)) u_dut_a (
    .clock            (clock),
    .reset            (reset),
    .valid_in         (valid_in),
    .flush            (flush),
    .mode             (mode),
    .ra_input         (ra),
    .rb_input         (rb),
    .I7_input         (i7),
    .rt_address_input (addr_in),
    .rt_value         (rt_value_a),
    .rt_address       (rt_address_a),
    .wrt_en           (wrt_en_a),
    .fw_valid         (fw_valid_a),
    .fw_addr          (fw_addr_a),
    .fw_value         (fw_value_a)
  );

  odd_shift_rotate_unit #(.DATA_W(64), .ADDR_W(7), .IMM_W(7), .STAGES(1)) u_dut_b (
    .clock            (clock),
    .reset            (reset),
    .valid_in         (valid_in),
    .flush            (flush),
    .mode             (mode),
    .ra_input         (ra[63:0]),
    .rb_input         (rb[63:0]),
    .I7_input         (i7),
    .rt_address_input (addr_in),
    .rt_value         (rt_value_b),
    .rt_address       (rt_address_b),
    .wrt_en           (wrt_en_b),
    .fw_valid         (fw_valid_b),
    .fw_addr          (fw_addr_b),
    .fw_value         (fw_value_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: walk big-endian bit positions; result bit i takes source bit i+n.
  function automatic logic [127:0] model(input logic [2:0] m, input logic [127:0] a,
                                         input logic [127:0] b, input logic [6:0] im,
                                         input int w);
    int bytes = w / 8;
    int rbv   = int'(b[15:0]);
    int iv    = int'(im);
    int nb    = 0;
    int j;
    bit rot   = 1'b0;
    logic [127:0] r = '0;
    case (m)
      3'd1: nb = rbv % 8;
      3'd2: nb = iv % 8;
      3'd3: nb = (rbv % (2 * bytes)) * 8;
      3'd4: nb = (iv % (2 * bytes)) * 8;
      3'd5: begin nb = rbv % 8;           rot = 1'b1; end
      3'd6: begin nb = (rbv % bytes) * 8; rot = 1'b1; end
      3'd7: begin nb = (iv % bytes) * 8;  rot = 1'b1; end
      default: return '0;
    endcase
    for (int i = 0; i < w; i++) begin
      j = i + nb;
      if (rot) j = j % w;
      if (j < w) r[w-1-i] = a[w-1-j];
    end
    return r;
  endfunction

  // Compare each output cycle against the head of the queue, or require idle.
  always @(negedge clock) begin
    if (mon_en) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        check("a_wrt_en", {127'b0, wrt_en_a}, 128'd1);
        check("a_rt_value", rt_value_a, qa[0].val);
        check("a_rt_address", {121'b0, rt_address_a}, {121'b0, qa[0].addr});
        void'(qa.pop_front());
      end else begin
        check("a_idle_wrt_en", {127'b0, wrt_en_a}, 128'd0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        check("b_wrt_en", {127'b0, wrt_en_b}, 128'd1);
        check("b_rt_value", {64'b0, rt_value_b}, qb[0].val);
        check("b_rt_address", {121'b0, rt_address_b}, {121'b0, qb[0].addr});
        void'(qb.pop_front());
      end else begin
        check("b_idle_wrt_en", {127'b0, wrt_en_b}, 128'd0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    flush    = 1'b0;
    mode     = 3'd0;
    ra       = '0;
    rb       = '0;
    i7       = '0;
    addr_in  = '0;
  endtask

  // Entries not yet at the output are killed by the coming edge.
  task automatic kill_pending();
    while (qa.size() > 0 && qa[qa.size()-1].due > cyc) void'(qa.pop_back());
    while (qb.size() > 0 && qb[qb.size()-1].due > cyc) void'(qb.pop_back());
  endtask

  task automatic issue(input logic [2:0] m, input logic [127:0] a, input logic [127:0] b,
                       input logic [6:0] im, input logic [6:0] ad,
                       input bit has_exp = 1'b0, input logic [127:0] ea = '0);
    exp_t e;
    valid_in = 1'b1;
    flush    = 1'b0;
    mode     = m;
    ra       = a;
    rb       = b;
    i7       = im;
    addr_in  = ad;
    if (m != 3'd0) begin
      e.addr = ad;
      e.due  = cyc + 4;
      e.val  = has_exp ? ea : model(m, a, b, im, 128);
      qa.push_back(e);
      e.due  = cyc + 1;
      e.val  = model(m, {64'b0, a[63:0]}, {64'b0, b[63:0]}, im, 64);
      qb.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_wrt_en"}, {127'b0, wrt_en_a}, 128'd0);
    check({tag, "_a_rt_value"}, rt_value_a, 128'd0);
    check({tag, "_a_rt_address"}, {121'b0, rt_address_a}, 128'd0);
    check({tag, "_a_fw_valid"}, {124'b0, fw_valid_a}, 128'd0);
    check({tag, "_a_fw_addr"}, {100'b0, fw_addr_a}, 128'd0);
    check({tag, "_a_fw_value"}, {127'b0, |fw_value_a}, 128'd0);
    check({tag, "_b_wrt_en"}, {127'b0, wrt_en_b}, 128'd0);
    check({tag, "_b_rt_value"}, {64'b0, rt_value_b}, 128'd0);
    check({tag, "_b_fw_valid"}, {127'b0, fw_valid_b}, 128'd0);
  endtask

  logic [2:0]   rm;
  logic [127:0] rra;
  logic [127:0] rrb;
  logic [6:0]   ri7;

  initial begin
    reset = 1'b0;
    idle();
    step();
    step();
    @(negedge clock);
    check_all_zero("reset");
    step();
    reset  = 1'b1;
    mon_en = 1'b1;

    // Single SHLQBI, latency and forwarding-tap walk.
    step();
    issue(3'd1, 128'd20, 128'd10, 7'd0, 7'd3, 1'b1, 128'd80);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("a_fw_valid_walk", {124'b0, fw_valid_a}, 128'd1 << k);
      if (k == 0) begin
        check("a_fw_value_s1", fw_value_a[127:0], 128'd80);
        check("a_fw_addr_s1", {121'b0, fw_addr_a[6:0]}, 128'd3);
        check("b_fw_valid_s1", {127'b0, fw_valid_b}, 128'd1);
      end
      if (k == 1) check("b_fw_valid_after", {127'b0, fw_valid_b}, 128'd0);
      step();
    end
    repeat (2) step();

    // Immediate and byte forms, including byte count past the end.
    issue(3'd2, 128'd15, 'x, 7'd5, 7'd4, 1'b1, 128'd480);
    step();
    issue(3'd4, 128'd1, 'x, 7'd3, 7'd5, 1'b1, 128'd1 << 24);
    step();
    issue(3'd3, {128{1'b1}}, 128'd16, 'x, 7'd6, 1'b1, 128'd0);
    step();
    // Rotates: bit wrap and byte count taken mod 16.
    issue(3'd5, {1'b1, 126'b0, 1'b1}, 128'd1, 'x, 7'd7, 1'b1, 128'd3);
    step();
    issue(3'd6, {8'h01, 120'b0}, 128'd17, 'x, 7'd8, 1'b1, 128'd1);
    step();
    issue(3'd7, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 'x, 7'd19, 7'd9);
    step();
    issue(3'd0, 128'hdead, 128'd1, 7'd1, 7'd10);
    step();
    idle();
    repeat (6) step();

    // Eight back-to-back ops, addresses 1..8.
    for (int k = 1; k <= 8; k++) begin
      issue(3'((k % 7) + 1), {$urandom, $urandom, $urandom, $urandom}, 128'(k * 3),
            7'(k * 5), 7'(k));
      step();
    end
    idle();
    repeat (6) step();

    // Three ops, then flush on the cycle of a fourth, then a normal op.
    for (int k = 0; k < 3; k++) begin
      issue(3'd1, 128'(k + 100), 128'd1, 7'd0, 7'(20 + k));
      step();
    end
    kill_pending();
    valid_in = 1'b1;
    flush    = 1'b1;
    mode     = 3'd1;
    ra       = 128'd555;
    rb       = 128'd1;
    addr_in  = 7'd23;
    step();
    issue(3'd3, 128'hffff_0000, 128'd2, 7'd0, 7'd24);
    step();
    idle();
    repeat (6) step();

    // Reset with two ops in flight.
    issue(3'd5, 128'd9, 128'd3, 7'd0, 7'd30);
    step();
    issue(3'd6, 128'd9, 128'd3, 7'd0, 7'd31);
    step();
    idle();
    kill_pending();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("midreset");
    repeat (6) step();

    // Random mix including NOPs; the unused count operand is driven X.
    for (int k = 0; k < 40; k++) begin
      rm  = 3'($urandom_range(0, 7));
      rra = {$urandom, $urandom, $urandom, $urandom};
      rrb = {$urandom, $urandom, $urandom, $urandom};
      ri7 = 7'($urandom_range(0, 127));
      if (rm == 3'd2 || rm == 3'd4 || rm == 3'd7) rrb = 'x;
      else ri7 = 'x;
      issue(rm, rra, rrb, ri7, 7'($urandom_range(0, 127)));
      step();
    end
    idle();
    repeat (8) step();
    check("a_drain", 128'(qa.size()), 128'd0);
    check("b_drain", 128'(qb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/odd_shift_rotate_unit.md
Name: odd_shift_rotate_unit

Overview:
Parametrised, fully pipelined quadword shift/rotate unit for the odd pipe. It generalises the first-stage SHLQBI/SHLQBII logic to byte shifts, rotates, a configurable datapath width and a configurable pipeline depth. It adds a valid/flush pipeline and per-stage forwarding taps. It sits in oddpipe beside the permute and branch units, and drives the odd-pipe writeback mux.

Parameters:
DATA_W, 128, datapath width in bits; a multiple of 8 and at least 16.
ADDR_W, 7, register-file address width.
IMM_W, 7, immediate width (I7).
STAGES, 4, pipeline depth and result latency in cycles; at least 1.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset.
valid_in  in  1  instruction present this cycle.
flush  in  1  kill all in-flight and incoming operations.
mode  in  3  0 NOP, 1 SHLQBI, 2 SHLQBII, 3 SHLQBY, 4 SHLQBYI, 5 ROTQBI, 6 ROTQBY, 7 ROTQBYI.
ra_input  in  DATA_W  source operand.
rb_input  in  DATA_W  count operand (register forms).
I7_input  in  IMM_W  count operand (immediate forms).
rt_address_input  in  ADDR_W  destination register.
rt_value  out  DATA_W  result.
rt_address  out  ADDR_W  destination of the result.
wrt_en  out  1  result valid; register-file write enable.
fw_valid  out  STAGES  per-stage valid; bit s is stage s+1.
fw_addr  out  STAGES*ADDR_W  per-stage destination; slice s = stage s+1.
fw_value  out  STAGES*DATA_W  per-stage result; slice s = stage s+1.

Behaviour:
- Bit numbering is big-endian: bit 0 is the MSB. "Left" means toward bit 0. BYTES = DATA_W/8.
- Count sources: the register forms use the low bits of rb_input (rightmost). The immediate forms use the low bits of I7_input.
- SHLQBI and SHLQBII:
  - Count = low 3 bits of the source (0-7).
  - Shift left by bits, zero fill.
- SHLQBY and SHLQBYI:
  - Count = low (clog2(BYTES)+1) bits (5 bits at 128).
  - Shift left by count bytes, zero fill. Any count >= BYTES gives an all-zero result.
- ROTQBI: rotate left by the low 3 bits of rb_input; bits leaving bit 0 re-enter at bit DATA_W-1.
- ROTQBY and ROTQBYI: rotate left by (low clog2(BYTES) bits) bytes, i.e. the count is taken mod BYTES.
- NOP: accepted into the pipeline with valid forced to 0. It never asserts wrt_en or fw_valid.
- Result timing:
  - The result is computed combinationally from the inputs and captured in stage 1.
  - Stages 2..STAGES are plain delay registers carrying valid, address and value.
  - Latency is exactly STAGES cycles: an input accepted at edge N appears on wrt_en/rt_value/rt_address after edge N+STAGES-1.
  - rt_value, rt_address and wrt_en equal stage STAGES; no extra register.
- Throughput is one op per cycle with no back-pressure, no stall and no internal state machine beyond the valid shift chain.
- Flush:
  - At the edge where flush=1, every stage valid clears, and the valid_in of that cycle is dropped.
  - The value and address registers may keep stale data, but all outputs are gated by valid: when a valid bit is 0, the corresponding value and address outputs read as 0.
- Reset (reset=0 at an edge):
  - Clears all valids, values and addresses to 0, so wrt_en=0, rt_value=0, rt_address=0, fw_*=0.
  - Reset mid-operation discards all in-flight ops.
  - Reset has priority over flush, and flush has priority over valid_in.
- Back-to-back ops with the same rt_address are independent; no hazard logic lives here. The fw_* ports let the issue stage forward results.
- X on rb_input or I7_input when that input is not used by the selected mode must not propagate to the result.

Test Plan:
1. DATA_W=128, STAGES=4: SHLQBI, ra=20, rb=10 (count 2) -> wrt_en=1 exactly 4 cycles later with rt_value=80; fw_valid walks 0001 -> 0010 -> 0100 -> 1000.
2. SHLQBII, ra=15, I7=5 -> rt_value=480. Then SHLQBYI, ra=1, I7=3 -> rt_value=1<<24. Then SHLQBY, ra=all-ones, rb=16 -> rt_value=0.
3. ROTQBI, ra=128'h8000_..._0001, rb=1 -> rt_value=128'h0..03. ROTQBY, ra=128'h01_00.._00, rb=17 (count mod 16 = 1) -> rt_value=128'h00..01.
4. Eight consecutive valid ops with distinct rt_address 1..8 -> eight consecutive wrt_en pulses, in order, with no gaps.
5. Issue 3 ops, assert flush for one cycle on the cycle of the 4th op -> none of the 4 ever assert wrt_en. An op issued the cycle after the flush completes normally.
6. Drive reset=0 for one cycle while 2 ops are in flight -> all outputs 0 on the next cycle, no wrt_en afterward. Repeat tests 1 and 4 with STAGES=1 and DATA_W=64 to check latency 1 and byte-count wrap at 8.
